lc3b_dmem_responder: RTL and testbench

Data-memory responder for the LC-3b pipeline. It is the slave end of the data-memory port driven by the MEM stage: it accepts the `d_mem_read`/`d_mem_write` requests that the decoded control word raises and answers them. Each request completes after a programmable latency with a one-cycle `mem_resp` strobe. Used as the behavioural data memory in pipeline simulation and as the latency model for stall and forwarding tests.

---
 rtl/lc3b_dmem_responder.sv | 102 ++++++++++
 tb/tb_lc3b_dmem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_dmem_responder.sv
// Behavioural data memory for the LC-3b MEM stage: answers held read/write
// requests after LATENCY cycles with a one-cycle mem_resp strobe.
module lc3b_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        mem_err
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [15:0]     mem [DEPTH_WORDS];

  logic [14:0]     word_addr;
  logic [AW-1:0]   idx;
  logic            req;
  logic            commit;
  logic            unused_addr_bits;

  assign word_addr        = mem_address[15:1];
  assign idx              = word_addr[AW-1:0];
  assign unused_addr_bits = ^{mem_address[0], word_addr};
  assign req              = d_mem_read | d_mem_write;

  // Commit happens on the request's LATENCY-th sampled edge; LATENCY=1 skips BUSY.
  always_comb begin
    commit = 1'b0;
    if (req) begin
      if (state == IDLE && LATENCY == 1)
        commit = 1'b1;
      else if (state == BUSY && cnt == CW'(1))
        commit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      if (commit) begin
        mem_resp <= 1'b1;
        state    <= RESP;
        cnt      <= '0;
        if (d_mem_read && d_mem_write) begin
          mem_err   <= 1'b1;
          mem_rdata <= '0;
        end else if (d_mem_read) begin
          mem_rdata <= mem[idx];
        end
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              cnt   <= CW'(LATENCY - 1);
              state <= BUSY;
            end
          end
          BUSY: begin
            if (!req)
              state <= IDLE;
            else
              cnt <= cnt - CW'(1);
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Array is deliberately not reset; a conflicting read+write never stores.
  always_ff @(posedge clk) begin
    if (rst_n && commit && d_mem_write && !d_mem_read) begin
      if (mem_byte_enable[0]) mem[idx][7:0]  <= mem_wdata[7:0];
      if (mem_byte_enable[1]) mem[idx][15:8] <= mem_wdata[15:8];
    end
  end

endmodule

// File: tb/tb_lc3b_dmem_responder.sv
// Bench for lc3b_dmem_responder: three latencies (2, 4, 1) share one stimulus
// stream; a transaction-level model is checked every cycle plus literal checks.
module tb_lc3b_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;

  logic [2:0]       resp_o;
  logic [2:0][15:0] rdata_o;
  logic [2:0]       err_o;

  int n_vec;
  int n_bad;
  int cyc;
  int c0;

  lc3b_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .d_mem_read(rd), .d_mem_write(wr),
    .mem_address(addr), .mem_wdata(wdata), .mem_byte_enable(be),
    .mem_resp(resp_o[0]), .mem_rdata(rdata_o[0]), .mem_err(err_o[0]));

  lc3b_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .d_mem_read(rd), .d_mem_write(wr),
    .mem_address(addr), .mem_wdata(wdata), .mem_byte_enable(be),
    .mem_resp(resp_o[1]), .mem_rdata(rdata_o[1]), .mem_err(err_o[1]));

  lc3b_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .d_mem_read(rd), .d_mem_write(wr),
    .mem_address(addr), .mem_wdata(wdata), .mem_byte_enable(be),
    .mem_resp(resp_o[2]), .mem_rdata(rdata_o[2]), .mem_err(err_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a request completes on its LATENCY-th consecutive sampled edge.
  int          lat [3];
  int          age [3];
  bit          in_resp [3];
  logic [15:0] e_rdata [3];
  bit          e_known [3];
  bit          e_err [3];
  logic [15:0] mm [3][256];
  bit          mk [3][256];
  bit          model_on;

  initial begin
    int wi;
    lat[0] = 2; lat[1] = 4; lat[2] = 1;
    model_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      age[i] = 0; in_resp[i] = 1'b0; e_rdata[i] = '0; e_known[i] = 1'b0; e_err[i] = 1'b0;
      for (int j = 0; j < 256; j++) begin mm[i][j] = '0; mk[i][j] = 1'b0; end
    end
    forever begin
      @(negedge clk);
      if (model_on) begin
        for (int i = 0; i < 3; i++) begin
          n_vec++;
          if (resp_o[i] !== in_resp[i]) begin
            n_bad++;
            $display("FAIL model_resp L%0d cyc %0d: got %b want %b", lat[i], cyc, resp_o[i], in_resp[i]);
          end
          n_vec++;
          if (err_o[i] !== e_err[i]) begin
            n_bad++;
            $display("FAIL model_err L%0d cyc %0d: got %b want %b", lat[i], cyc, err_o[i], e_err[i]);
          end
          if (e_known[i]) begin
            n_vec++;
            if (rdata_o[i] !== e_rdata[i]) begin
              n_bad++;
              $display("FAIL model_rdata L%0d cyc %0d: got %h want %h", lat[i], cyc, rdata_o[i], e_rdata[i]);
            end
          end
        end
      end
      wi = int'(addr[8:1]);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          age[i] = 0; in_resp[i] = 1'b0; e_rdata[i] = '0; e_known[i] = 1'b1; e_err[i] = 1'b0;
          model_on = 1'b1;
        end else if (in_resp[i]) begin
          in_resp[i] = 1'b0;
        end else if (!(rd || wr)) begin
          age[i] = 0;
        end else begin
          age[i]++;
          if (age[i] == lat[i]) begin
            age[i] = 0;
            in_resp[i] = 1'b1;
            if (rd && wr) begin
              e_err[i] = 1'b1; e_rdata[i] = '0; e_known[i] = 1'b1;
            end else if (wr) begin
              if (be[0]) mm[i][wi][7:0]  = wdata[7:0];
              if (be[1]) mm[i][wi][15:8] = wdata[15:8];
              if (be == 2'b11) mk[i][wi] = 1'b1;
            end else begin
              e_rdata[i] = mm[i][wi]; e_known[i] = mk[i][wi];
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  logic [15:0] hist [3];
  logic [15:0] ldata [3];

  task automatic start();
    @(posedge clk); #3;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin hist[i] = '0; ldata[i] = '0; end
  endtask

  task automatic at(input int k);
    while (cyc < c0 + k) begin @(posedge clk); #3; end
  endtask

  task automatic obs(input int k);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      if (resp_o[i]) begin hist[i][k] = 1'b1; ldata[i] = rdata_o[i]; end
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] b);
    rd = r; wr = w; addr = a; wdata = d; be = b;
  endtask

  task automatic xfer(input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] b, input int hold);
    start();
    drive(r, w, a, d, b);
    for (int k = 0; k <= hold + 2; k++) begin
      at(k);
      if (k == hold) drive(1'b0, 1'b0, a, d, b);
      obs(k);
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp", int'(resp_o[0]), 0);
    chk("reset_rdata", int'(rdata_o[0]), 0);
    chk("reset_err", int'(err_o[0]), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Preload word 0x10 then read it back
    xfer(1'b0, 1'b1, 16'h0020, 16'hBEEF, 2'b11, 4);
    chk("wr_lat_l2", int'(hist[0]), 16'h0004);
    xfer(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 4);
    chk("rd_lat_l2", int'(hist[0]), 16'h0004);
    chk("rd_data_l2", int'(ldata[0]), 16'hBEEF);
    chk("rd_lat_l4", int'(hist[1]), 16'h0010);
    chk("rd_data_l4", int'(ldata[1]), 16'hBEEF);
    chk("rd_lat_l1", int'(hist[2]), 16'h000A);

    // Byte enables on word 0x05
    xfer(1'b0, 1'b1, 16'h000A, 16'h1234, 2'b11, 4);
    xfer(1'b0, 1'b1, 16'h000A, 16'hABCD, 2'b10, 4);
    chk("be10_lat", int'(hist[0]), 16'h0004);
    xfer(1'b1, 1'b0, 16'h000A, 16'h0000, 2'b00, 4);
    chk("be10_data", int'(ldata[0]), 16'hAB34);
    xfer(1'b0, 1'b1, 16'h000A, 16'hABCD, 2'b01, 4);
    xfer(1'b1, 1'b0, 16'h000A, 16'h0000, 2'b00, 4);
    chk("be01_data", int'(ldata[0]), 16'hABCD);
    xfer(1'b0, 1'b1, 16'h000A, 16'h0000, 2'b00, 4);
    chk("be00_lat", int'(hist[0]), 16'h0004);
    xfer(1'b1, 1'b0, 16'h000A, 16'h0000, 2'b00, 4);
    chk("be00_data", int'(ldata[0]), 16'hABCD);

    // Back-to-back: write then read, read presented from the RESP cycle
    start();
    drive(1'b0, 1'b1, 16'h0002, 16'h5555, 2'b11);
    for (int k = 0; k <= 7; k++) begin
      at(k);
      if (k == 2) drive(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00);
      if (k == 5) drive(1'b0, 1'b0, 16'h0002, 16'h0000, 2'b00);
      obs(k);
    end
    chk("b2b_spacing", int'(hist[0]), 16'h0024);
    chk("b2b_data", int'(ldata[0]), 16'h5555);

    // Abort on L4: drop in cycle 2
    xfer(1'b0, 1'b1, 16'h0004, 16'h0BAD, 2'b11, 4);
    xfer(1'b0, 1'b1, 16'h0004, 16'hFFFF, 2'b11, 2);
    chk("abort_noresp_l4", int'(hist[1]), 0);
    chk("abort_l2_done", int'(hist[0]), 16'h0004);
    xfer(1'b1, 1'b0, 16'h0004, 16'h0000, 2'b00, 4);
    chk("abort_old_l4", int'(ldata[1]), 16'h0BAD);
    chk("abort_new_l2", int'(ldata[0]), 16'hFFFF);

    // Conflicting read+write
    xfer(1'b1, 1'b1, 16'h0000, 16'h1111, 2'b11, 4);
    chk("err_lat", int'(hist[0]), 16'h0004);
    chk("err_rdata", int'(ldata[0]), 0);
    chk("err_flag", int'(err_o[0]), 1);

    // Address wrap: 0x0202 aliases word 0x01
    xfer(1'b0, 1'b1, 16'h0202, 16'hC0DE, 2'b11, 4);
    xfer(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 4);
    chk("wrap_data", int'(ldata[0]), 16'hC0DE);
    chk("err_sticky", int'(err_o[0]), 1);

    // Mid-operation reset
    xfer(1'b0, 1'b1, 16'h0006, 16'h3333, 2'b11, 4);
    start();
    drive(1'b0, 1'b1, 16'h0006, 16'h7777, 2'b11);
    for (int k = 0; k <= 5; k++) begin
      at(k);
      if (k == 1) rst_n = 1'b0;
      if (k == 3) begin rst_n = 1'b1; drive(1'b0, 1'b0, 16'h0006, 16'h0000, 2'b00); end
      obs(k);
    end
    chk("rst_noresp_l2", int'(hist[0]), 0);
    chk("rst_err_clr", int'(err_o[0]), 0);
    chk("rst_rdata_clr", int'(rdata_o[0]), 0);
    xfer(1'b1, 1'b0, 16'h0006, 16'h0000, 2'b00, 4);
    chk("rst_word_l2", int'(ldata[0]), 16'h3333);
    chk("rst_word_l4", int'(ldata[1]), 16'h3333);
    chk("l1_lat", int'(hist[2]), 16'h000A);
    chk("l1_data", int'(ldata[2]), 16'h7777);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
